// File: rtl/pam4_symbol_mapper_if.sv
// pam4_symbol_mapper_if
// Bundles the word-input handshake and the symbol-output handshake of the
// PAM4 symbol mapper into one interface.
//   data_in    word to transmit (DATA_WIDTH bits)
//   d_valid    data_in valid
//   d_ready    mapper can accept a word this cycle
//   symbol_out signed PAM4 level, SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH bits
//   sym_code   raw 2-bit symbol currently presented
//   s_valid    symbol_out/sym_code valid
//   s_ready    downstream accepts the symbol
//   sym_count  running count of transferred symbols (wraps)
// Modports: master = upstream source / downstream sink side,
//           slave  = the mapper itself.
interface pam4_symbol_mapper_if #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int DATA_WIDTH            = 8
);
  logic [DATA_WIDTH-1:0]                                    data_in;
  logic                                                     d_valid;
  logic                                                     d_ready;
  logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] symbol_out;
  logic [1:0]                                               sym_code;
  logic                                                     s_valid;
  logic                                                     s_ready;
  logic [31:0]                                              sym_count;

  modport master (
    output data_in, d_valid, s_ready,
    input  d_ready, symbol_out, sym_code, s_valid, sym_count
  );

  modport slave (
    input  data_in, d_valid, s_ready,
    output d_ready, symbol_out, sym_code, s_valid, sym_count
  );
endinterface

// File: rtl/pam4_symbol_mapper.sv
// pam4_symbol_mapper
// Tx-side PAM4 mapper: accepts DATA_WIDTH-bit words over a valid/ready
// handshake and emits DATA_WIDTH/2 two-bit symbols per word, LSB pair first,
// each mapped to a signed PAM4 level (+/-S/2, +/-3S/2). Words stream back to
// back: a new word is loaded in the same cycle the last symbol transfers.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pam4_symbol_mapper_if.slave (data_in/d_valid/d_ready in,
//        symbol_out/sym_code/s_valid/s_ready/sym_count out)
// Configuration macro: PAM4_GRAY_EN selects Gray level mapping
// (00,01,11,10 -> L0..L3); undefined selects natural binary mapping.
module pam4_symbol_mapper #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int SYMBOL_SEPERATION     = 56,
  parameter int DATA_WIDTH            = 8
) (
  input logic                  clk,
  input logic                  rst,
  pam4_symbol_mapper_if.slave  bus
);

  localparam int OUT_W   = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
  localparam int NUM_SYM = DATA_WIDTH / 2;
  localparam int IDX_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

  localparam logic signed [OUT_W-1:0] LVL0 = OUT_W'(-3 * SYMBOL_SEPERATION / 2);
  localparam logic signed [OUT_W-1:0] LVL1 = OUT_W'(-SYMBOL_SEPERATION / 2);
  localparam logic signed [OUT_W-1:0] LVL2 = OUT_W'(SYMBOL_SEPERATION / 2);
  localparam logic signed [OUT_W-1:0] LVL3 = OUT_W'(3 * SYMBOL_SEPERATION / 2);

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    shiftReg_q, shiftReg_d;
  logic [IDX_W-1:0]         symIdx_q, symIdx_d;
  logic signed [OUT_W-1:0]  symbol_q, symbol_d;
  logic [31:0]              symCount_q, symCount_d;

  logic dReady;
  logic sValid;
  logic accept;
  logic transfer;

  function automatic logic signed [OUT_W-1:0] mapLevel(input logic [1:0] code);
    logic signed [OUT_W-1:0] lvl;
`ifdef PAM4_GRAY_EN
    case (code)
      2'b00:   lvl = LVL0;
      2'b01:   lvl = LVL1;
      2'b11:   lvl = LVL2;
      default: lvl = LVL3;
    endcase
`else
    case (code)
      2'b00:   lvl = LVL0;
      2'b01:   lvl = LVL1;
      2'b10:   lvl = LVL2;
      default: lvl = LVL3;
    endcase
`endif
    return lvl;
  endfunction

  // State register: every piece of state, including the mapped level, lives
  // here so the outputs never see a combinational path from data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      shiftReg_q <= '0;
      symIdx_q   <= '0;
      symbol_q   <= '0;
      symCount_q <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      symIdx_q   <= symIdx_d;
      symbol_q   <= symbol_d;
      symCount_q <= symCount_d;
    end
  end

  // Next-state logic. The last symbol transferring together with a new accept
  // reloads the shifter directly, which is what keeps words bubble-free.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    symIdx_d   = symIdx_q;
    symCount_d = transfer ? symCount_q + 32'd1 : symCount_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = HOLD;
          shiftReg_d = bus.data_in;
          symIdx_d   = '0;
        end
      end
      HOLD: begin
        if (transfer) begin
          if (symIdx_q == LAST_IDX) begin
            if (accept) begin
              shiftReg_d = bus.data_in;
              symIdx_d   = '0;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            shiftReg_d = shiftReg_q >> 2;
            symIdx_d   = symIdx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // Level is precomputed for the symbol that will be presented next cycle.
    symbol_d = (state_d == HOLD) ? mapLevel(shiftReg_d[1:0]) : '0;
  end

  // Output logic. d_ready depends only on state and s_ready, never d_valid.
  always_comb begin
    sValid   = (state_q == HOLD);
    dReady   = !rst && ((state_q == EMPTY) || (bus.s_ready && (symIdx_q == LAST_IDX)));
    accept   = bus.d_valid && dReady;
    transfer = sValid && bus.s_ready;
  end

  assign bus.d_ready    = dReady;
  assign bus.s_valid    = sValid;
  assign bus.symbol_out = symbol_q;
  assign bus.sym_code   = shiftReg_q[1:0];
  assign bus.sym_count  = symCount_q;

endmodule
